// File: rtl/conv_top_system.sv
// Streaming 3x3 convolution MAC engine. Operand pairs arrive over the shared
// con buses, and each 36-beat group is reduced to one 32-bit result. The result
// is driven back on the same buses for a single cycle.

// Signed multiplier: full-width product of two signed operands.
module conv_mul #(
    parameter int W = 16
) (
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    output logic signed [2*W-1:0] p
);
    assign p = a * b;
endmodule

// Wrapping adder: the sum is taken modulo 2^W, with no saturation.
module conv_add #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] s
);
    assign s = a + b;
endmodule

module conv_top_system #(
    parameter int IO_DATA_WIDTH      = 16,
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int EXT_MEM_HEIGHT     = 1 << 20,
    parameter int EXT_MEM_WIDTH      = 32,
    parameter int FEATURE_MAP_WIDTH  = 64,
    parameter int FEATURE_MAP_HEIGHT = 64,
    parameter int INPUT_NB_CHANNELS  = 4,
    parameter int OUTPUT_NB_CHANNELS = 32,
    parameter int KERNEL_SIZE        = 3
) (
    input  logic                                  clk,
    input  logic                                  arst_n_in,
    inout  wire  [IO_DATA_WIDTH-1:0]              con_1,
    inout  wire  [IO_DATA_WIDTH-1:0]              con_2,
    inout  wire  [IO_DATA_WIDTH-1:0]              con_3,
    input  logic                                  con_valid,
    output logic                                  con_ready,
    output logic                                  output_valid,
    output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
    output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
    output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch,
    input  logic                                  start,
    output logic                                  running,
    output logic                                  driving_cons
);
    localparam int IOW   = IO_DATA_WIDTH;
    localparam int AW    = ACCUMULATION_WIDTH;
    localparam int TAPS  = KERNEL_SIZE * KERNEL_SIZE * INPUT_NB_CHANNELS;
    localparam int TAP_W = $clog2(TAPS);
    localparam int XW    = $clog2(FEATURE_MAP_WIDTH);
    localparam int YW    = $clog2(FEATURE_MAP_HEIGHT);
    localparam int CW    = $clog2(OUTPUT_NB_CHANNELS);

    // The result is split across two IO-wide buses, so the accumulator must be
    // exactly twice the IO width. The external-memory parameters are reserved
    // and must only be sane.
    if (AW != 2 * IOW || EXT_MEM_HEIGHT < 1 || EXT_MEM_WIDTH < 1) begin : g_bad_cfg
        $error("conv_top_system: inconsistent configuration parameters");
    end

    typedef enum logic [1:0] {IDLE, LOAD, OUT} state_t;

    state_t           state, state_nxt;
    logic [TAP_W-1:0] tap_cnt;
    logic [XW-1:0]    x_cnt;
    logic [YW-1:0]    y_cnt;
    logic [CW-1:0]    co_cnt;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    acc_base;
    logic [AW-1:0]    acc_sum;
    logic [2*IOW-1:0] prod;

    logic beat, last_tap, last_co, last_x, last_y, last_res;

    assign beat     = (state == LOAD) && con_valid;
    assign last_tap = (tap_cnt == TAP_W'(TAPS - 1));
    assign last_co  = (co_cnt == CW'(OUTPUT_NB_CHANNELS - 1));
    assign last_x   = (x_cnt == XW'(FEATURE_MAP_WIDTH - 1));
    assign last_y   = (y_cnt == YW'(FEATURE_MAP_HEIGHT - 1));
    assign last_res = last_co && last_x && last_y;

    // State register
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next-state logic. OUT always lasts exactly one cycle because the result
    // has no backpressure.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (beat && last_tap) state_nxt = OUT;
            OUT:     state_nxt = last_res ? IDLE : LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    assign con_ready    = (state == LOAD);
    assign output_valid = (state == OUT);
    assign driving_cons = (state == OUT);
    assign running      = (state != IDLE);
    assign output_x     = x_cnt;
    assign output_y     = y_cnt;
    assign output_ch    = co_cnt;

    assign con_1 = driving_cons ? acc[IOW-1:0]  : {IOW{1'bz}};
    assign con_2 = driving_cons ? acc[AW-1:IOW] : {IOW{1'bz}};
    assign con_3 = driving_cons ? {IOW{1'b0}}   : {IOW{1'bz}};

    // The first tap of each group restarts the sum instead of adding to the
    // previous result.
    assign acc_base = (tap_cnt == '0) ? '0 : acc;

    conv_mul #(.W(IOW)) u_mul (
        .a (con_1),
        .b (con_2),
        .p (prod)
    );

    conv_add #(.W(AW)) u_add (
        .a (acc_base),
        .b (prod),
        .s (acc_sum)
    );

    // Accumulate one product per accepted beat
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in)  acc <= '0;
        else if (beat)   acc <= acc_sum;
    end

    // Tap counter over (ky, kx, ci). The data order is owned by the sender, so
    // a flat count is all the core needs.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in)  tap_cnt <= '0;
        else if (beat)   tap_cnt <= last_tap ? '0 : tap_cnt + TAP_W'(1);
    end

    // Output coordinate counters: co fastest, then x, then y. They advance as
    // each result leaves, and they restart on a fresh start.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            co_cnt <= '0;
            x_cnt  <= '0;
            y_cnt  <= '0;
        end else if (state == IDLE && start) begin
            co_cnt <= '0;
            x_cnt  <= '0;
            y_cnt  <= '0;
        end else if (state == OUT) begin
            co_cnt <= last_co ? '0 : co_cnt + CW'(1);
            if (last_co) begin
                x_cnt <= last_x ? '0 : x_cnt + XW'(1);
                if (last_x) y_cnt <= last_y ? '0 : y_cnt + YW'(1);
            end
        end
    end

endmodule

// File: tb/tb_conv_top_system.sv
// Scoreboarded bench for conv_top_system, run on a reduced 8x8 map with
// 4 output channels so a complete pass stays short.
module tb_conv_top_system;
    localparam int IOW  = 16;
    localparam int FMW  = 8;
    localparam int FMH  = 8;
    localparam int IC   = 4;
    localparam int OC   = 4;
    localparam int K    = 3;
    localparam int TAPS = K * K * IC;
    localparam int XW   = $clog2(FMW);
    localparam int YW   = $clog2(FMH);
    localparam int CW   = $clog2(OC);

    logic clk = 1'b0;
    logic arst_n_in = 1'b0;
    logic con_valid = 1'b0;
    logic start = 1'b0;
    logic [IOW-1:0] d1 = '0, d2 = '0, d3 = '0;
    wire  [IOW-1:0] con_1, con_2, con_3;
    logic con_ready, output_valid, running, driving_cons;
    logic [XW-1:0] output_x;
    logic [YW-1:0] output_y;
    logic [CW-1:0] output_ch;

    // The bench drives the buses only while the DUT has released them
    assign con_1 = driving_cons ? {IOW{1'bz}} : d1;
    assign con_2 = driving_cons ? {IOW{1'bz}} : d2;
    assign con_3 = driving_cons ? {IOW{1'bz}} : d3;

    conv_top_system #(
        .IO_DATA_WIDTH(IOW), .ACCUMULATION_WIDTH(32), .EXT_MEM_HEIGHT(1 << 20),
        .EXT_MEM_WIDTH(32), .FEATURE_MAP_WIDTH(FMW), .FEATURE_MAP_HEIGHT(FMH),
        .INPUT_NB_CHANNELS(IC), .OUTPUT_NB_CHANNELS(OC), .KERNEL_SIZE(K)
    ) dut (
        .clk(clk), .arst_n_in(arst_n_in), .con_1(con_1), .con_2(con_2),
        .con_3(con_3), .con_valid(con_valid), .con_ready(con_ready),
        .output_valid(output_valid), .output_x(output_x), .output_y(output_y),
        .output_ch(output_ch), .start(start), .running(running),
        .driving_cons(driving_cons)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [YW-1:0] y;
        logic [XW-1:0] x;
        logic [CW-1:0] ch;
        logic [31:0]   res;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int n_vec = 0;
    int n_err = 0;
    logic [IOW-1:0] act [FMH][FMW][IC];
    logic [IOW-1:0] wgt [OC][K][K][IC];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input int y, input int x, input int co, input logic [31:0] r);
        exp_t e;
        e.y = YW'(y); e.x = XW'(x); e.ch = CW'(co); e.res = r;
        sb.push_back(e);
    endtask

    // Present one operand pair and hold it until accepted (bounded wait)
    task automatic beat(input logic [IOW-1:0] a, input logic [IOW-1:0] w, output bit ok);
        int t;
        ok = 1'b1;
        @(negedge clk);
        con_valid = 1'b1; d1 = a; d2 = w; d3 = IOW'($urandom);
        t = 0;
        while (con_ready !== 1'b1) begin
            if (t >= 100) begin
                check("beat_timeout", {63'd0, con_ready}, 64'd1);
                con_valid = 1'b0;
                ok = 1'b0;
                return;
            end
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1 con_valid = 1'b0;
    endtask

    task automatic send_const(input logic [IOW-1:0] a, input logic [IOW-1:0] w, input int n);
        bit ok;
        for (int i = 0; i < n; i++) begin
            beat(a, w, ok);
            if (!ok) return;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("start_to_load", {62'd0, running, con_ready}, 64'd3);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    // Stream the map in (y, x, co, ky, kx, ci) order and zero the padding
    // taps. The run can stop after a chosen beat of a chosen result index.
    task automatic run_map(input int abort_idx, input int abort_beat);
        int idx, acc, yy, xx;
        bit ok;
        logic [IOW-1:0] av [TAPS];
        logic [IOW-1:0] wv [TAPS];
        idx = 0;
        for (int y = 0; y < FMH; y++)
            for (int x = 0; x < FMW; x++)
                for (int co = 0; co < OC; co++) begin
                    acc = 0;
                    for (int ky = 0; ky < K; ky++)
                        for (int kx = 0; kx < K; kx++)
                            for (int ci = 0; ci < IC; ci++) begin
                                int t = (ky * K + kx) * IC + ci;
                                yy = y + ky - 1;
                                xx = x + kx - 1;
                                av[t] = (yy >= 0 && yy < FMH && xx >= 0 && xx < FMW) ? act[yy][xx][ci] : '0;
                                wv[t] = wgt[co][ky][kx][ci];
                                acc += int'($signed(av[t])) * int'($signed(wv[t]));
                            end
                    if (idx != abort_idx) push(y, x, co, acc);
                    for (int t = 0; t < TAPS; t++) begin
                        beat(av[t], wv[t], ok);
                        if (!ok) return;
                        if (idx == abort_idx && t + 1 == abort_beat) return;
                    end
                    idx++;
                end
    endtask

    // Scoreboard monitor: every result must match the next expected entry
    always @(negedge clk) begin
        if (arst_n_in === 1'b1 && output_valid === 1'b1) begin
            check("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("coord", {49'd0, output_y, output_x, output_ch}, {49'd0, mon_e.y, mon_e.x, mon_e.ch});
                check("result", {32'd0, con_2, con_1}, {32'd0, mon_e.res});
                check("con3_zero", {48'd0, con_3}, 64'd0);
                check("out_flags", {61'd0, con_ready, driving_cons, running}, 64'd3);
            end
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int acc;
        logic [IOW-1:0] ra, rw;

        // Reset, then stay idle
        d1 = 16'hA5A5;
        repeat (3) @(negedge clk);
        check("rst_outs", {51'd0, running, con_ready, output_valid, driving_cons, output_y, output_x, output_ch}, 64'd0);
        check("rst_bus_released", {48'd0, con_1}, 64'hA5A5);
        arst_n_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle", {60'd0, running, con_ready, output_valid, driving_cons}, 64'd0);
        end

        // First result: all 1*2 gives 72, exactly one cycle after beat 36
        pulse_start();
        push(0, 0, 0, 32'd72);
        send_const(16'd1, 16'd2, TAPS);
        @(negedge clk);
        check("out_latency", {61'd0, output_valid, driving_cons, con_ready}, 64'd6);

        // Signed corner and wrap: 36 * 2^30 wraps to 0, then -3*5*36 = -540
        push(0, 0, 1, 32'd0);
        send_const(16'h8000, 16'h8000, TAPS);
        push(0, 0, 2, 32'hFFFF_FDE4);
        send_const(16'hFFFD, 16'd5, TAPS);

        // Stall mid-result with a stray start, which must be ignored
        acc = 0;
        for (int t = 0; t < TAPS; t++) begin
            if (t == 18) begin
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    start = (s == 2);
                    check("stall_wait", {61'd0, running, con_ready, output_valid}, 64'd6);
                end
                start = 1'b0;
            end
            ra = IOW'($urandom);
            rw = IOW'($urandom);
            acc += int'($signed(ra)) * int'($signed(rw));
            if (t == 0) push(0, 0, 3, 32'd0);
            sb[sb.size() - 1].res = acc;
            beat(ra, rw, ok);
        end
        push(0, 1, 0, 32'hFFFF_FF04);
        send_const(16'd7, 16'hFFFF, TAPS);
        drain();

        // Full map against the golden model
        arst_n_in = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        arst_n_in = 1'b1;
        foreach (act[y, x, c]) act[y][x][c] = IOW'($urandom);
        foreach (wgt[o, a, b, c]) wgt[o][a][b][c] = IOW'($urandom);
        pulse_start();
        run_map(-1, 0);
        drain();
        @(negedge clk);
        check("end_idle", {61'd0, running, con_ready, output_valid}, 64'd0);
        repeat (5) @(negedge clk);
        check("end_stays_idle", {61'd0, running, con_ready, driving_cons}, 64'd0);

        // Abort at beat 20 of (y=0, x=5, co=3), then restart from origin
        pulse_start();
        run_map((0 * FMW + 5) * OC + 3, 20);
        arst_n_in = 1'b0;
        #1;
        check("abort_outs", {51'd0, running, con_ready, output_valid, driving_cons, output_y, output_x, output_ch}, 64'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        arst_n_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_abort_idle", {61'd0, running, con_ready, output_valid}, 64'd0);
        end
        pulse_start();
        push(0, 0, 0, 32'd108);
        send_const(16'd1, 16'd3, TAPS);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/conv_top_system.md
Name:
conv_top_system

Overview:
- Top-level streaming 2-D convolution accelerator (3x3 kernel, stride 1, zero padding) for one feature map: 64x64, 4 input channels, 32 output channels.
- The bench streams operand pairs in over shared bidirectional buses (con_1..con_3).
- The block multiply-accumulates them and returns one 32-bit result per output pixel/channel over the same buses.
- It is the DUT driven by the team's intf/testprogram environment.

Parameters:
- IO_DATA_WIDTH, 16: width of each con bus and of each operand (signed two's complement).
- ACCUMULATION_WIDTH, 32: accumulator/result width; must equal 2*IO_DATA_WIDTH.
- EXT_MEM_HEIGHT, 1<<20: reserved, no functional effect.
- EXT_MEM_WIDTH, 32: reserved, no functional effect.
- FEATURE_MAP_WIDTH, 64: output columns (x).
- FEATURE_MAP_HEIGHT, 64: output rows (y).
- INPUT_NB_CHANNELS, 4: input channels (ci).
- OUTPUT_NB_CHANNELS, 32: output channels (co).
- KERNEL_SIZE, 3: kernel side.

Ports:
- clk  in  1  single clock, rising edge.
- arst_n_in  in  1  asynchronous active-low reset.
- con_1  inout  IO_DATA_WIDTH  in: activation; out: result[15:0].
- con_2  inout  IO_DATA_WIDTH  in: weight; out: result[31:16].
- con_3  inout  IO_DATA_WIDTH  in: ignored; out: zero.
- con_valid  in  1  bench has a valid operand pair on con_1/con_2.
- con_ready  out  1  DUT accepts an operand pair this cycle.
- output_valid  out  1  result valid on con_1/con_2 this cycle.
- output_x  out  $clog2(FEATURE_MAP_WIDTH)  x of current result.
- output_y  out  $clog2(FEATURE_MAP_HEIGHT)  y of current result.
- output_ch  out  $clog2(OUTPUT_NB_CHANNELS)  co of current result.
- start  in  1  start pulse.
- running  out  1  computation in progress.
- driving_cons  out  1  DUT drives con_1..con_3; the bench must release them.

Behaviour:
- Reset (arst_n_in=0, asynchronous): state IDLE, all counters 0, accumulator 0, con_ready=0, output_valid=0, running=0, driving_cons=0, output_x/y/ch=0, con buses high-Z.
- Reset asserted mid-operation aborts immediately. No further outputs until a new start.
- States and transitions:
  - IDLE -> LOAD when start=1.
  - LOAD -> OUT after the last tap is accepted.
  - OUT -> LOAD for the next pixel/channel, or OUT -> IDLE after the final result.
  - start is ignored outside IDLE.
- IDLE -> LOAD: on the cycle after start, running=1 and con_ready=1.
- Loop order: y (outer), x, co, then taps ky, kx, ci (ci innermost). Each (y,x,co) takes exactly KERNEL_SIZE^2*INPUT_NB_CHANNELS = 36 beats.
- Beat handshake: a beat is accepted on the rising edge where con_valid=1 and con_ready=1. con_valid=0 stalls; no timeout.
- Padding taps (y+ky-1 or x+kx-1 outside the map) are still transferred; the bench sends activation 0. The DUT performs no bounds logic.
- MAC per beat: acc <= (first tap ? 0 : acc) + signed(con_1)*signed(con_2).
  - Full 32-bit signed product.
  - Accumulation wraps modulo 2^32 (no saturation).
- OUT state, exactly one cycle, starting the cycle after the 36th beat:
  - con_ready=0, driving_cons=1, output_valid=1.
  - con_1=acc[15:0], con_2=acc[31:16], con_3=0.
  - output_x/y/ch = coordinates of this result.
  - No backpressure; the bench samples on that edge.
- After OUT, return to LOAD (con_ready=1 next cycle) with counters advanced:
  - co wraps at 32 and increments x.
  - x wraps at 64 and increments y.
- After the OUT of (y=63,x=63,co=31): IDLE, running=0 on the next cycle, con_ready=0, total 131072 results.
- running stays high from the cycle after start through the final OUT cycle inclusive.
- driving_cons=1 only in OUT. Otherwise con buses are high-Z.
- con_ready is never 1 in the same cycle as output_valid.
- Datapath adders/multipliers use the team's adder/multiplier modules (area/energy accounting), not plain operators.

Test Plan:
- Reset then idle: arst_n_in low, then high, no start -> running=0, con_ready=0, output_valid=0, driving_cons=0 for 20 cycles.
- Single result: start, send 36 beats all con_1=1, con_2=2 -> one cycle after beat 36: output_valid=1, x=0, y=0, ch=0, con_1=72, con_2=0, driving_cons=1.
- Signed/wrap: beats con_1=-32768, con_2=-32768 (x36) -> result 36*2^30 mod 2^32 = 0; con_1=-3, con_2=5 (x36) -> result -540 (con_1=0xFDE4, con_2=0xFFFF).
- Stall: drop con_valid for 5 cycles mid-pixel -> the same result as unstalled; start pulses during running are ignored.
- Full run: random 16-bit data, zero padding per loop order -> 131072 results matching a software golden model, ordered (y,x,co) with correct coordinates; running falls after the last.
- Reset mid-run: assert arst_n_in at beat 20 of pixel (0,5,3) -> all outputs 0 asynchronously; a new start restarts at (0,0,0).
